data_mem_arbiter: RTL and testbench
===================================

Name: data_mem_arbiter

Overview:
- Shares the single-port 256x8 data memory between two requesters: requester 0 (processor core load/store) and requester 1 (host loader/debug port).
- The block sits directly in front of the data memory. It drives that memory's address, write-data and write-enable, and takes its combinational read data.
- Arbitration is round-robin, with an optional bounded lock so a requester can hold the memory for back-to-back accesses.
- Read data is returned registered, one cycle after the grant.

Parameters:
- ADDR_W, 8, address width (256 bytes).
- DATA_W, 8, data width.
- MAX_HOLD, 4, max consecutive locked grants before a contending requester is forced in (must be >= 1).

Ports:
- Clk  in  1  clock, all state on posedge.
- Reset  in  1  synchronous, active-high reset.
- Req0, Req1  in  1  access request; must be held with We/Addr/Wdata stable until the matching Gnt.
- We0, We1  in  1  1=write, 0=read.
- Lock0, Lock1  in  1  request to keep ownership on following cycles.
- Addr0, Addr1  in  ADDR_W  access address.
- Wdata0, Wdata1  in  DATA_W  write data.
- Gnt0, Gnt1  out  1  combinational grant; the access executes in this cycle.
- Rvalid0, Rvalid1  out  1  registered; read data valid, one cycle after a granted read.
- Rdata0, Rdata1  out  DATA_W  registered read data.
- MemAddress  out  ADDR_W  to memory address.
- MemDataIn  out  DATA_W  to memory write data.
- MemWriteEn  out  1  to memory write enable.
- MemDataOut  in  DATA_W  from memory combinational read data.

Behaviour:
- State:
  - rr_last (1 bit): last requester granted.
  - owner: OWN_NONE, OWN_R0 or OWN_R1.
  - hold_cnt: 0..MAX_HOLD, saturating.
- Reset (sync): rr_last=1 (so requester 0 wins first), owner=OWN_NONE, hold_cnt=0, Rvalid0/1=0, Rdata0/1=0.
  - While Reset=1, Gnt0/1=0 and MemWriteEn=0, regardless of requests.
  - A read granted in the cycle Reset asserts produces no Rvalid.
- Grant selection, each cycle, combinational, at most one Gnt:
  - Neither Req: no grant; MemAddress=0, MemDataIn=0, MemWriteEn=0.
  - Exactly one Req: that requester is granted.
  - Both Req, owner=OWN_Rn, Lockn=1, hold_cnt<MAX_HOLD: requester n is granted.
  - Both Req, otherwise: the requester != rr_last is granted.
- Memory drive: MemAddress=Addr of the granted requester; MemDataIn=its Wdata; MemWriteEn=Gnt&We of that requester.
- Read return:
  - On a granted read, the next posedge sets Rvalidn=1 and Rdatan=MemDataOut.
  - The other requester's Rvalid stays 0.
  - Rvalid is a one-cycle pulse unless reads are granted back-to-back.
  - Rdata holds its last value when Rvalid=0.
- Writes have no response; the write completes at the posedge ending the Gnt cycle.
- State update on posedge when requester n is granted:
  - rr_last<=n.
  - If Lockn=1: owner<=OWN_Rn. hold_cnt<=hold_cnt+1 if owner was already OWN_Rn (saturating at MAX_HOLD), else hold_cnt<=1.
  - If Lockn=0: owner<=OWN_NONE and hold_cnt<=0.
- No grant in a cycle: owner<=OWN_NONE, hold_cnt<=0.
- Lock release:
  - Owner dropping Req or Lock releases the lock in that same cycle; normal round-robin applies.
  - Owner reaching MAX_HOLD while the other requester requests: the other is granted next cycle and ownership transfers or clears per its Lock.
  - Owner reaching MAX_HOLD with no contention: owner keeps being granted, hold_cnt stays saturated.
- Same-address read after write: the read, granted in a later cycle, returns the new value. No forwarding is needed.

Decomposition:
- Package data_mem_pkg holds:
  - ADDR_W and DATA_W constants.
  - owner_e enum {OWN_NONE, OWN_R0, OWN_R1}.
  - mem_req_t struct {req, we, lock, addr, wdata}.
- One sub-module, dm_rr_pick: combinational grant decision from Req0/1, Lock0/1, owner, hold_cnt and rr_last, producing one-hot grant.
- The top module holds the state registers, the memory mux and the read-return registers.

Test Plan:
- Reset, then Req0 write Addr0=8'h10 Wdata0=8'hA5 alone -> Gnt0=1 and MemWriteEn=1 that cycle. A later Req1 read of 8'h10 -> Gnt1, and next cycle Rvalid1=1, Rdata1=8'hA5, Rvalid0=0.
- Req0 and Req1 both held continuously, no Lock, for 6 cycles starting right after reset -> grants alternate 0,1,0,1,0,1.
- Req0+Lock0 reads at 0x00..0x07 with Req1 held continuously, MAX_HOLD=4:
  - Gnt0 for 4 cycles, then Gnt1 for 1 cycle, then Gnt0 again (hold_cnt restarts at 1).
- Req0+Lock0 with no competitor for 10 cycles -> Gnt0 every cycle. hold_cnt saturates at 4; MemAddress tracks Addr0.
- Reset asserted in a cycle where Req1 reads and Req0 writes -> no Gnt, MemWriteEn=0. Next cycle Rvalid0/1=0 and Rdata=0. First post-reset contention goes to requester 0.
- Owner drops Lock0 mid-burst (after 2 grants) with Req1 pending -> that cycle grants requester 1 (rr_last=0); owner=OWN_NONE.

Source files
------------

// File: rtl/data_mem_pkg.sv
// Shared types and constants for the data memory arbiter.
//   ADDR_W / DATA_W : data memory geometry (256 x 8)
//   owner_e         : which requester currently holds a lock
//   mem_req_t       : one requester's access request bundle
package data_mem_pkg;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 8;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_R0   = 2'd1,
    OWN_R1   = 2'd2
  } owner_e;

  typedef struct packed {
    logic              req;
    logic              we;
    logic              lock;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } mem_req_t;

endpackage

// File: rtl/dm_rr_pick.sv
// Combinational grant decision for the two-requester data memory arbiter.
//   req_i[1:0]  : access requests (bit n = requester n)
//   lock_i[1:0] : requester wants to keep ownership
//   owner_i     : current lock owner
//   hold_cnt_i  : consecutive locked grants of the current owner
//   rr_last_i   : last requester granted
//   gnt_o[1:0]  : one-hot grant (all zero when nobody requests)
module dm_rr_pick
  import data_mem_pkg::*;
#(
  parameter int MAX_HOLD = 4,
  parameter int HOLD_W   = $clog2(MAX_HOLD + 1)
) (
  input  logic [1:0]        req_i,
  input  logic [1:0]        lock_i,
  input  owner_e            owner_i,
  input  logic [HOLD_W-1:0] hold_cnt_i,
  input  logic              rr_last_i,
  output logic [1:0]        gnt_o
);

  logic hold_ok;
  assign hold_ok = hold_cnt_i < HOLD_W'(MAX_HOLD);

  always_comb begin
    gnt_o = 2'b00;
    if (req_i == 2'b01 || req_i == 2'b10) begin
      gnt_o = req_i;
    end else if (req_i == 2'b11) begin
      // A lock only wins under contention while its budget lasts; once the
      // owner drops Lock or saturates, plain round-robin takes over.
      if (owner_i == OWN_R0 && lock_i[0] && hold_ok)      gnt_o = 2'b01;
      else if (owner_i == OWN_R1 && lock_i[1] && hold_ok) gnt_o = 2'b10;
      else if (rr_last_i)                                 gnt_o = 2'b01;
      else                                                gnt_o = 2'b10;
    end
  end

endmodule

// File: rtl/data_mem_arbiter.sv
// Round-robin arbiter sharing a single-port 256x8 data memory between the
// core (requester 0) and the host loader/debug port (requester 1), with a
// bounded lock for back-to-back bursts.
//   Clk, Reset            : clock, synchronous active-high reset
//   ReqN/WeN/LockN        : request, write select, lock request
//   AddrN/WdataN          : access address and write data
//   GntN                  : combinational grant, access executes this cycle
//   RvalidN/RdataN        : registered read return, one cycle after grant
//   MemAddress/MemDataIn/MemWriteEn : drive to the memory
//   MemDataOut            : combinational read data from the memory
module data_mem_arbiter #(
  parameter int ADDR_W   = data_mem_pkg::ADDR_W,
  parameter int DATA_W   = data_mem_pkg::DATA_W,
  parameter int MAX_HOLD = 4
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Req0,
  input  logic              Req1,
  input  logic              We0,
  input  logic              We1,
  input  logic              Lock0,
  input  logic              Lock1,
  input  logic [ADDR_W-1:0] Addr0,
  input  logic [ADDR_W-1:0] Addr1,
  input  logic [DATA_W-1:0] Wdata0,
  input  logic [DATA_W-1:0] Wdata1,
  output logic              Gnt0,
  output logic              Gnt1,
  output logic              Rvalid0,
  output logic              Rvalid1,
  output logic [DATA_W-1:0] Rdata0,
  output logic [DATA_W-1:0] Rdata1,
  output logic [ADDR_W-1:0] MemAddress,
  output logic [DATA_W-1:0] MemDataIn,
  output logic              MemWriteEn,
  input  logic [DATA_W-1:0] MemDataOut
);
  import data_mem_pkg::*;

  localparam int HOLD_W = $clog2(MAX_HOLD + 1);

  mem_req_t r0, r1;
  assign r0 = '{req: Req0, we: We0, lock: Lock0, addr: Addr0, wdata: Wdata0};
  assign r1 = '{req: Req1, we: We1, lock: Lock1, addr: Addr1, wdata: Wdata1};

  logic              rr_last_q, rr_last_d;
  owner_e            owner_q, owner_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic [1:0]        rvalid_q, rvalid_d;
  logic [DATA_W-1:0] rdata0_q, rdata1_q;

  logic [1:0] pick, gnt;

  dm_rr_pick #(.MAX_HOLD(MAX_HOLD), .HOLD_W(HOLD_W)) u_pick (
    .req_i      ({r1.req, r0.req}),
    .lock_i     ({r1.lock, r0.lock}),
    .owner_i    (owner_q),
    .hold_cnt_i (hold_q),
    .rr_last_i  (rr_last_q),
    .gnt_o      (pick)
  );

  // Nothing reaches the memory while in reset, so no write or read fires.
  assign gnt  = Reset ? 2'b00 : pick;
  assign Gnt0 = gnt[0];
  assign Gnt1 = gnt[1];

  always_comb begin
    MemAddress = '0;
    MemDataIn  = '0;
    MemWriteEn = 1'b0;
    if (gnt[0]) begin
      MemAddress = r0.addr;
      MemDataIn  = r0.wdata;
      MemWriteEn = r0.we;
    end else if (gnt[1]) begin
      MemAddress = r1.addr;
      MemDataIn  = r1.wdata;
      MemWriteEn = r1.we;
    end
  end

  // Next state: a lock extends only if the same requester already owned it.
  always_comb begin
    rr_last_d = rr_last_q;
    owner_d   = OWN_NONE;
    hold_d    = '0;
    rvalid_d  = {gnt[1] & ~r1.we, gnt[0] & ~r0.we};
    if (gnt[0]) begin
      rr_last_d = 1'b0;
      if (r0.lock) begin
        owner_d = OWN_R0;
        if (owner_q != OWN_R0)                hold_d = HOLD_W'(1);
        else if (hold_q == HOLD_W'(MAX_HOLD)) hold_d = hold_q;
        else                                  hold_d = hold_q + HOLD_W'(1);
      end
    end else if (gnt[1]) begin
      rr_last_d = 1'b1;
      if (r1.lock) begin
        owner_d = OWN_R1;
        if (owner_q != OWN_R1)                hold_d = HOLD_W'(1);
        else if (hold_q == HOLD_W'(MAX_HOLD)) hold_d = hold_q;
        else                                  hold_d = hold_q + HOLD_W'(1);
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      rr_last_q <= 1'b1;
      owner_q   <= OWN_NONE;
      hold_q    <= '0;
      rvalid_q  <= 2'b00;
      rdata0_q  <= '0;
      rdata1_q  <= '0;
    end else begin
      rr_last_q <= rr_last_d;
      owner_q   <= owner_d;
      hold_q    <= hold_d;
      rvalid_q  <= rvalid_d;
      if (rvalid_d[0]) rdata0_q <= MemDataOut;
      if (rvalid_d[1]) rdata1_q <= MemDataOut;
    end
  end

  assign Rvalid0 = rvalid_q[0];
  assign Rvalid1 = rvalid_q[1];
  assign Rdata0  = rdata0_q;
  assign Rdata1  = rdata1_q;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Directed vector bench for data_mem_arbiter with a 256x8 memory model.
module tb_data_mem_arbiter;
  import data_mem_pkg::*;

  logic       Clk = 1'b0;
  logic       Reset;
  logic       Req0, Req1, We0, We1, Lock0, Lock1;
  logic [7:0] Addr0, Addr1, Wdata0, Wdata1;
  logic       Gnt0, Gnt1, Rvalid0, Rvalid1, MemWriteEn;
  logic [7:0] Rdata0, Rdata1, MemAddress, MemDataIn, MemDataOut;

  data_mem_arbiter #(.ADDR_W(8), .DATA_W(8), .MAX_HOLD(4)) dut (
    .Clk(Clk), .Reset(Reset),
    .Req0(Req0), .Req1(Req1), .We0(We0), .We1(We1),
    .Lock0(Lock0), .Lock1(Lock1),
    .Addr0(Addr0), .Addr1(Addr1), .Wdata0(Wdata0), .Wdata1(Wdata1),
    .Gnt0(Gnt0), .Gnt1(Gnt1), .Rvalid0(Rvalid0), .Rvalid1(Rvalid1),
    .Rdata0(Rdata0), .Rdata1(Rdata1),
    .MemAddress(MemAddress), .MemDataIn(MemDataIn), .MemWriteEn(MemWriteEn),
    .MemDataOut(MemDataOut)
  );

  always #5 Clk = ~Clk;

  // Memory model: preloaded with mem[a] = a + 0x30.
  logic [7:0] mem [256];
  logic       mem_init;
  assign MemDataOut = mem[MemAddress];
  always @(posedge Clk) begin
    if (mem_init) begin
      for (int i = 0; i < 256; i++) mem[i] <= 8'(i + 8'h30);
    end else if (MemWriteEn) begin
      mem[MemAddress] <= MemDataIn;
    end
  end

  typedef struct packed {
    logic       rst;
    mem_req_t   a, b;
    logic [2:0] g;      // {Gnt0, Gnt1, MemWriteEn}
    logic [7:0] addr, din;
    logic [1:0] rv;     // {Rvalid0, Rvalid1}
    logic [7:0] rd0, rd1;
  } vec_t;

  vec_t tv[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  function automatic mem_req_t rq(logic req, logic we, logic lk, logic [7:0] ad, logic [7:0] wd);
    mem_req_t r;
    r = '{req: req, we: we, lock: lk, addr: ad, wdata: wd};
    return r;
  endfunction

  function automatic vec_t mk(logic rst, mem_req_t a, mem_req_t b, logic [2:0] g,
                              logic [7:0] addr, logic [7:0] din, logic [1:0] rv,
                              logic [7:0] rd0, logic [7:0] rd1);
    vec_t v;
    v = '{rst: rst, a: a, b: b, g: g, addr: addr, din: din, rv: rv, rd0: rd0, rd1: rd1};
    return v;
  endfunction

  task automatic drive(logic rst, mem_req_t a, mem_req_t b);
    Reset = rst;
    Req0 = a.req; We0 = a.we; Lock0 = a.lock; Addr0 = a.addr; Wdata0 = a.wdata;
    Req1 = b.req; We1 = b.we; Lock1 = b.lock; Addr1 = b.addr; Wdata1 = b.wdata;
  endtask

  task automatic check(string name, logic [31:0] got, logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  mem_req_t IDL;

  initial begin
    IDL = '0;
    // write 0x10 <- A5, then read it back from requester 1
    tv.push_back(mk(0, rq(1,1,0,8'h10,8'hA5), IDL, 3'b101, 8'h10, 8'hA5, 2'b00, 8'h00, 8'h00));
    tv.push_back(mk(0, IDL, rq(1,0,0,8'h10,8'h00), 3'b010, 8'h10, 8'h00, 2'b00, 8'h00, 8'h00));
    tv.push_back(mk(0, IDL, IDL,                   3'b000, 8'h00, 8'h00, 2'b01, 8'h00, 8'hA5));
    // reset during a contended write/read: nothing granted, returns cleared
    tv.push_back(mk(1, rq(1,1,0,8'h20,8'h77), rq(1,0,0,8'h10,8'h00), 3'b000, 8'h00, 8'h00, 2'b00, 8'h00, 8'hA5));
    tv.push_back(mk(0, IDL, IDL,                   3'b000, 8'h00, 8'h00, 2'b00, 8'h00, 8'h00));
    // plain contention alternates, requester 0 first after reset
    tv.push_back(mk(0, rq(1,0,0,8'h20,8'h00), rq(1,0,0,8'h02,8'h00), 3'b100, 8'h20, 8'h00, 2'b00, 8'h00, 8'h00));
    tv.push_back(mk(0, rq(1,0,0,8'h20,8'h00), rq(1,0,0,8'h02,8'h00), 3'b010, 8'h02, 8'h00, 2'b10, 8'h50, 8'h00));
    tv.push_back(mk(0, rq(1,0,0,8'h20,8'h00), rq(1,0,0,8'h02,8'h00), 3'b100, 8'h20, 8'h00, 2'b01, 8'h50, 8'h32));
    tv.push_back(mk(0, rq(1,0,0,8'h20,8'h00), rq(1,0,0,8'h02,8'h00), 3'b010, 8'h02, 8'h00, 2'b10, 8'h50, 8'h32));
    tv.push_back(mk(0, rq(1,0,0,8'h20,8'h00), rq(1,0,0,8'h02,8'h00), 3'b100, 8'h20, 8'h00, 2'b01, 8'h50, 8'h32));
    tv.push_back(mk(0, rq(1,0,0,8'h20,8'h00), rq(1,0,0,8'h02,8'h00), 3'b010, 8'h02, 8'h00, 2'b10, 8'h50, 8'h32));
    tv.push_back(mk(0, IDL, IDL,                   3'b000, 8'h00, 8'h00, 2'b01, 8'h50, 8'h32));
    // locked burst vs. persistent requester 1: 4 x Gnt0, 1 x Gnt1, Gnt0 again
    tv.push_back(mk(0, rq(1,0,1,8'h00,8'h00), rq(1,0,0,8'h40,8'h00), 3'b100, 8'h00, 8'h00, 2'b00, 8'h50, 8'h32));
    tv.push_back(mk(0, rq(1,0,1,8'h01,8'h00), rq(1,0,0,8'h40,8'h00), 3'b100, 8'h01, 8'h00, 2'b10, 8'h30, 8'h32));
    tv.push_back(mk(0, rq(1,0,1,8'h02,8'h00), rq(1,0,0,8'h40,8'h00), 3'b100, 8'h02, 8'h00, 2'b10, 8'h31, 8'h32));
    tv.push_back(mk(0, rq(1,0,1,8'h03,8'h00), rq(1,0,0,8'h40,8'h00), 3'b100, 8'h03, 8'h00, 2'b10, 8'h32, 8'h32));
    tv.push_back(mk(0, rq(1,0,1,8'h04,8'h00), rq(1,0,0,8'h40,8'h00), 3'b010, 8'h40, 8'h00, 2'b10, 8'h33, 8'h32));
    tv.push_back(mk(0, rq(1,0,1,8'h04,8'h00), rq(1,0,0,8'h40,8'h00), 3'b100, 8'h04, 8'h00, 2'b01, 8'h33, 8'h70));
    tv.push_back(mk(0, rq(1,0,1,8'h05,8'h00), IDL,                   3'b100, 8'h05, 8'h00, 2'b10, 8'h34, 8'h70));
    tv.push_back(mk(0, IDL, IDL,                   3'b000, 8'h00, 8'h00, 2'b10, 8'h35, 8'h70));
    // owner drops Lock after 2 grants with requester 1 pending
    tv.push_back(mk(0, rq(1,0,1,8'h08,8'h00), IDL,                   3'b100, 8'h08, 8'h00, 2'b00, 8'h35, 8'h70));
    tv.push_back(mk(0, rq(1,0,1,8'h09,8'h00), rq(1,0,0,8'h41,8'h00), 3'b100, 8'h09, 8'h00, 2'b10, 8'h38, 8'h70));
    tv.push_back(mk(0, rq(1,0,0,8'h0A,8'h00), rq(1,0,0,8'h41,8'h00), 3'b010, 8'h41, 8'h00, 2'b10, 8'h39, 8'h70));
    tv.push_back(mk(0, rq(1,0,0,8'h0A,8'h00), rq(1,0,0,8'h41,8'h00), 3'b100, 8'h0A, 8'h00, 2'b01, 8'h39, 8'h71));
    tv.push_back(mk(0, IDL, IDL,                   3'b000, 8'h00, 8'h00, 2'b10, 8'h3A, 8'h71));
    tv.push_back(mk(0, IDL, IDL,                   3'b000, 8'h00, 8'h00, 2'b00, 8'h3A, 8'h71));

    mem_init = 1'b1;
    drive(1'b1, IDL, IDL);
    @(posedge Clk); #1;
    mem_init = 1'b0;
    @(posedge Clk); #1;

    foreach (tv[i]) begin
      drive(tv[i].rst, tv[i].a, tv[i].b);
      @(negedge Clk);
      check($sformatf("vec%0d gnt/mem", i),
            {8'h0, 5'h0, Gnt0, Gnt1, MemWriteEn, MemAddress, MemDataIn},
            {8'h0, 5'h0, tv[i].g, tv[i].addr, tv[i].din});
      check($sformatf("vec%0d rvalid/rdata", i),
            {14'h0, Rvalid0, Rvalid1, Rdata0, Rdata1},
            {14'h0, tv[i].rv, tv[i].rd0, tv[i].rd1});
      @(posedge Clk); #1;
    end

    // uncontended lock: granted every cycle, hold count saturates
    for (int k = 0; k < 10; k++) begin
      drive(1'b0, rq(1,0,1,8'(8'h60 + k),8'h00), IDL);
      @(negedge Clk);
      check($sformatf("solo lock %0d", k), {22'h0, Gnt0, Gnt1, MemAddress},
            {22'h0, 2'b10, 8'(8'h60 + k)});
      @(posedge Clk); #1;
    end
    // saturated owner yields at once to a newcomer
    drive(1'b0, rq(1,0,1,8'h6A,8'h00), rq(1,0,0,8'h42,8'h00));
    @(negedge Clk);
    check("saturated yield", {22'h0, Gnt0, Gnt1, MemAddress}, {22'h0, 2'b01, 8'h42});
    @(posedge Clk); #1;
    drive(1'b0, rq(1,0,1,8'h6A,8'h00), IDL);
    @(negedge Clk);
    check("after yield gnt", {22'h0, Gnt0, Gnt1, MemAddress}, {22'h0, 2'b10, 8'h6A});
    check("after yield rdata", {22'h0, Rvalid0, Rvalid1, Rdata1}, {22'h0, 2'b01, 8'h72});
    @(posedge Clk); #1;
    drive(1'b0, IDL, IDL);
    @(posedge Clk); #1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
